// File: rtl/dma_engine_2d.sv
// rtl/dma_engine_2d.sv - single-channel 1D/2D word-copy DMA engine with one read outstanding
module dma_engine_2d #(
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dma_start,
    input  logic [31:0] dma_src_addr,
    input  logic [31:0] dma_dst_addr,
    input  logic [15:0] dma_size,
    input  logic        dma_mode_2d,
    input  logic [15:0] dma_row_count,
    input  logic [15:0] dma_col_count,
    input  logic [15:0] dma_src_stride,
    input  logic [15:0] dma_dst_stride,
    output logic        dma_busy,
    output logic        dma_done,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_gnt,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_gnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] src_row_q, src_row_d;
    logic [31:0] dst_row_q, dst_row_d;
    logic [15:0] src_stride_q, src_stride_d;
    logic [15:0] dst_stride_q, dst_stride_d;
    logic [15:0] rows_q, rows_d;
    logic [15:0] cols_q, cols_d;
    logic [15:0] row_idx_q, row_idx_d;
    logic [15:0] col_idx_q, col_idx_d;

    // 1D mode is handled as a single row of dma_size words
    logic [15:0] cfg_rows;
    logic [15:0] cfg_cols;
    logic        start_ok;
    logic        last_col;
    logic        last_row;
    logic [31:0] src_row_next;
    logic [31:0] dst_row_next;

    assign cfg_rows     = dma_mode_2d ? dma_row_count : 16'd1;
    assign cfg_cols     = dma_mode_2d ? dma_col_count : dma_size;
    assign start_ok     = dma_start && (state_q == IDLE || state_q == DONE);
    assign last_col     = (col_idx_q == cols_q - 16'd1);
    assign last_row     = (row_idx_q == rows_q - 16'd1);
    assign src_row_next = src_row_q + {16'd0, src_stride_q};
    assign dst_row_next = dst_row_q + {16'd0, dst_stride_q};

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        src_row_d    = src_row_q;
        dst_row_d    = dst_row_q;
        src_stride_d = src_stride_q;
        dst_stride_d = dst_stride_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        row_idx_d    = row_idx_q;
        col_idx_d    = col_idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    done_d       = 1'b0;
                    rd_addr_d    = dma_src_addr;
                    wr_addr_d    = dma_dst_addr;
                    src_row_d    = dma_src_addr;
                    dst_row_d    = dma_dst_addr;
                    src_stride_d = dma_src_stride;
                    dst_stride_d = dma_dst_stride;
                    rows_d       = cfg_rows;
                    cols_d       = cfg_cols;
                    row_idx_d    = 16'd0;
                    col_idx_d    = 16'd0;
                    if (cfg_rows == 16'd0 || cfg_cols == 16'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (rd_gnt) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_valid) begin
                    wr_data_d = rd_data;
                    state_d   = WR_REQ;
                end
            end
            WR_REQ: begin
                if (wr_gnt) begin
                    if (last_col && last_row) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (last_col) begin
                        src_row_d = src_row_next;
                        dst_row_d = dst_row_next;
                        rd_addr_d = src_row_next;
                        wr_addr_d = dst_row_next;
                        col_idx_d = 16'd0;
                        row_idx_d = row_idx_q + 16'd1;
                        state_d   = RD_REQ;
                    end else begin
                        rd_addr_d = rd_addr_q + STEP;
                        wr_addr_d = wr_addr_q + STEP;
                        col_idx_d = col_idx_q + 16'd1;
                        state_d   = RD_REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            rd_addr_q    <= 32'd0;
            wr_addr_q    <= 32'd0;
            wr_data_q    <= 32'd0;
            src_row_q    <= 32'd0;
            dst_row_q    <= 32'd0;
            src_stride_q <= 16'd0;
            dst_stride_q <= 16'd0;
            rows_q       <= 16'd0;
            cols_q       <= 16'd0;
            row_idx_q    <= 16'd0;
            col_idx_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            src_row_q    <= src_row_d;
            dst_row_q    <= dst_row_d;
            src_stride_q <= src_stride_d;
            dst_stride_q <= dst_stride_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            row_idx_q    <= row_idx_d;
            col_idx_q    <= col_idx_d;
        end
    end

    assign dma_busy = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
    assign dma_done = done_q;
    assign rd_req   = (state_q == RD_REQ);
    assign wr_req   = (state_q == WR_REQ);
    assign rd_addr  = rd_addr_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: doc/dma_engine_2d.md
DMA_ENGINE_2D -- requirements
Module: dma_engine_2d

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 4, byte increment between consecutive words in a row.
REQ-002 SHALL have port clock  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port dma_start  in  1  one-cycle start pulse from the register block.
REQ-005 SHALL have port dma_src_addr  in  32  source byte address.
REQ-006 SHALL have port dma_dst_addr  in  32  destination byte address.
REQ-007 SHALL have port dma_size  in  16  word count for 1D mode.
REQ-008 SHALL have port dma_mode_2d  in  1  1 selects 2D mode, 0 selects 1D mode.
REQ-009 SHALL have ports dma_row_count and dma_col_count  in  16 each  2D row count and words per row.
REQ-010 SHALL have ports dma_src_stride and dma_dst_stride  in  16 each  unsigned byte offsets between successive row bases.
REQ-011 SHALL have ports dma_busy and dma_done  out  1 each  transfer in progress, and sticky completion flag.
REQ-012 SHALL have ports rd_req out 1, rd_addr out 32, rd_gnt in 1, rd_valid in 1, rd_data in 32  read bus.
REQ-013 SHALL have ports wr_req out 1, wr_addr out 32, wr_data out 32, wr_gnt in 1  write bus.

Function
REQ-014 SHALL sample all configuration inputs into internal registers on the cycle a start is accepted; later input changes SHALL NOT affect the transfer in flight.
REQ-015 SHALL accept dma_start only in IDLE or DONE; a start seen in any other state SHALL be ignored.
REQ-016 SHALL use states IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
REQ-017 SHALL leave IDLE/DONE on start and enter RD_REQ, or enter DONE directly when the total is zero: size=0 in 1D, or rows=0 or cols=0 in 2D.
REQ-018 SHALL hold rd_req=1 with a stable rd_addr in RD_REQ, then move to RD_WAIT in the cycle after rd_gnt=1.
REQ-019 SHALL capture rd_data into a one-word buffer in RD_WAIT when rd_valid=1, then move to WR_REQ; rd_valid SHALL be ignored in all other states.
REQ-020 SHALL hold wr_req=1 with stable wr_addr and wr_data in WR_REQ, and treat the write as complete on rd_gnt's counterpart wr_gnt=1.
REQ-021 SHALL, on write completion, enter DONE if the word was the last one, and otherwise advance the pointers and return to RD_REQ.
REQ-022 SHALL keep at most one read outstanding and perform no read/write overlap, for a minimum of 3 cycles per word with zero-wait grants.
REQ-023 SHALL, in 1D mode, transfer size words at src+i*ADDR_STEP to dst+i*ADDR_STEP.
REQ-024 SHALL, in 2D mode, transfer word (r,c) from src+r*src_stride+c*ADDR_STEP to dst+r*dst_stride+c*ADDR_STEP, in row-major order with c innermost.
REQ-025 SHALL keep 32-bit row-base registers, each advanced by zero-extended stride at row end; address arithmetic SHALL wrap modulo 2^32.
REQ-026 SHALL drive dma_busy=1 exactly in RD_REQ, RD_WAIT and WR_REQ.
REQ-027 SHALL set dma_done=1 on entry to DONE, hold it in DONE, and clear it in the cycle a new start is accepted.
REQ-028 SHALL drive rd_req and wr_req low in every state other than RD_REQ and WR_REQ respectively.

Reset
REQ-029 SHALL, on reset and regardless of state (including mid-transfer), set state=IDLE, dma_busy=0, dma_done=0, rd_req=0, wr_req=0, rd_addr=0, wr_addr=0, wr_data=0, and clear all counters and pointers.
REQ-030 SHALL NOT complete any pending bus request after reset, and SHALL NOT assert rd_req in the cycle after reset deasserts unless dma_start is sampled.

Verification
REQ-031 1D: src=0x1000, dst=0x2000, size=3, zero-wait memory -> reads 0x1000/1004/1008, writes 0x2000/2004/2008 with matching data, dma_done rises 9-10 cycles after start.
REQ-032 2D: rows=2, cols=2, src=0x100, src_stride=0x40, dst=0x800, dst_stride=0x10 -> read order 0x100,0x104,0x140,0x144; write order 0x800,0x804,0x810,0x814.
REQ-033 Zero size: size=0, mode_2d=0 -> no rd_req, dma_busy never 1, dma_done=1 one cycle after start.
REQ-034 Backpressure: rd_gnt delayed 5 cycles and wr_gnt delayed 3 cycles -> rd_addr, wr_addr and wr_data stay stable and the data is correct.
REQ-035 Start while busy plus config changes mid-transfer -> ignored, and the original transfer completes unchanged.
REQ-036 Reset asserted in RD_WAIT -> all outputs are 0 the next cycle, and a subsequent start runs a clean transfer from word 0.
